befehls_abruf_einheit: RTL

Instruction fetch stage sitting directly upstream of the instruction decoder.
- Holds the program counter and reads one 32-bit instruction per step over a ready/valid memory read handshake.
- Presents the instruction on `Instruktion` and issues a clean one-cycle `DekodierSignal` pulse, which the decoder uses as a capture edge.
- Advances sequentially or to a jump target when the execute side signals completion via `Weiter`.

---
 rtl/befehls_abruf_einheit_if.sv | 30 +++
 rtl/befehls_abruf_einheit.sv | 181 ++++++++++++++++++
 2 files changed

// File: rtl/befehls_abruf_einheit_if.sv
`default_nettype none
// ============================================================================
// Module   : befehls_abruf_einheit_if
// Purpose  : Instruction memory read bus (ready/valid) between the fetch
//            stage (master) and the instruction memory (slave).
// Revision : 1.0  initial release
// ============================================================================
interface befehls_abruf_einheit_if #(
   parameter int ADRESSBREITE = 32
);
   logic [ADRESSBREITE-1:0] SpeicherAdresse;
   logic                    SpeicherLesen;
   logic                    SpeicherBereit;
   logic [31:0]             SpeicherDaten;

   modport master (
      output SpeicherAdresse,
      output SpeicherLesen,
      input  SpeicherBereit,
      input  SpeicherDaten
   );

   modport slave (
      input  SpeicherAdresse,
      input  SpeicherLesen,
      output SpeicherBereit,
      output SpeicherDaten
   );
endinterface
`default_nettype wire

// File: rtl/befehls_abruf_einheit.sv
`default_nettype none
// ============================================================================
// Module   : befehls_abruf_einheit
// Purpose  : Instruction fetch stage. Holds the PC, reads one instruction per
//            step over a ready/valid memory bus, presents it to the decoder
//            with a clean one-cycle DekodierSignal pulse and advances
//            sequentially or to a jump target on Weiter.
// Options  : VORABRUF_EN - one-word prefetch buffer filled while waiting.
// Revision : 1.0  initial release
// ============================================================================
module befehls_abruf_einheit #(
   parameter int                      ADRESSBREITE = 32,
   parameter logic [ADRESSBREITE-1:0] STARTADRESSE = '0
) (
   input  wire logic                    Clock,
   input  wire logic                    Reset,
   befehls_abruf_einheit_if.master      speicher,
   output logic [31:0]                  Instruktion,
   output logic                         DekodierSignal,
   output logic [ADRESSBREITE-1:0]      AktuellerPC,
   input  wire logic                    Weiter,
   input  wire logic                    SprungAktiv,
   input  wire logic                    SprungRelativ,
   input  wire logic [31:0]             SprungZiel,
   input  wire logic                    Anhalten
);

   localparam logic [ADRESSBREITE-1:0] c_eins = {{(ADRESSBREITE-1){1'b0}}, 1'b1};

   typedef enum logic [1:0] {
      HOLEN         = 2'd0,
      BEREITSTELLEN = 2'd1,
      AUSGABE       = 2'd2,
      WARTEN        = 2'd3
   } zustand_t;

   zustand_t                r_zustand;
   logic [ADRESSBREITE-1:0] r_pc;
   logic [ADRESSBREITE-1:0] r_adresse;
   logic                    r_lesen;
   logic [31:0]             r_instruktion;
   logic                    r_dekodier;
   logic [ADRESSBREITE-1:0] r_aktuellerPc;

`ifdef VORABRUF_EN
   logic [31:0]             r_pufferDaten;
   logic [ADRESSBREITE-1:0] r_pufferAdresse;
   logic                    r_pufferGueltig;
   // Set when a prefetch is still in flight but a jump made its data useless.
   logic                    r_verwerfen;
`endif

   logic [ADRESSBREITE-1:0] w_ziel;
   logic [ADRESSBREITE-1:0] w_folgePc;
   logic [ADRESSBREITE-1:0] w_naechsterPc;

   // Fit the 32-bit jump operand to the address width.
   generate
      if (ADRESSBREITE <= 32) begin : g_zielKuerzen
         assign w_ziel = SprungZiel[ADRESSBREITE-1:0];
      end else begin : g_zielErweitern
         assign w_ziel = {{(ADRESSBREITE-32){SprungZiel[31]}}, SprungZiel};
      end
   endgenerate

   // All PC arithmetic wraps silently modulo 2^ADRESSBREITE.
   assign w_folgePc     = r_aktuellerPc + c_eins;
   assign w_naechsterPc = !SprungAktiv  ? w_folgePc :
                          SprungRelativ ? r_aktuellerPc + w_ziel : w_ziel;

   assign speicher.SpeicherAdresse = r_adresse;
   assign speicher.SpeicherLesen   = r_lesen;
   assign Instruktion              = r_instruktion;
   assign DekodierSignal           = r_dekodier;
   assign AktuellerPC              = r_aktuellerPc;

   // Fetch sequencer: all outputs registered; reset drops SpeicherLesen at once.
   always_ff @(posedge Clock or posedge Reset) begin
      if (Reset) begin
         r_zustand       <= HOLEN;
         r_pc            <= STARTADRESSE;
         r_adresse       <= STARTADRESSE;
         r_lesen         <= 1'b0;
         r_instruktion   <= 32'h0;
         r_dekodier      <= 1'b0;
         r_aktuellerPc   <= STARTADRESSE;
`ifdef VORABRUF_EN
         r_pufferDaten   <= 32'h0;
         r_pufferAdresse <= STARTADRESSE;
         r_pufferGueltig <= 1'b0;
         r_verwerfen     <= 1'b0;
`endif
      end else begin
         case (r_zustand)
            HOLEN: begin
`ifdef VORABRUF_EN
               if (r_verwerfen) begin
                  // Let the stale prefetch finish, then issue the jump target.
                  if (speicher.SpeicherBereit) begin
                     r_lesen     <= 1'b0;
                     r_verwerfen <= 1'b0;
                  end
               end else
`endif
               if (r_lesen) begin
                  if (speicher.SpeicherBereit) begin
                     r_instruktion <= speicher.SpeicherDaten;
                     r_aktuellerPc <= r_pc;
                     r_lesen       <= 1'b0;
                     r_zustand     <= BEREITSTELLEN;
                  end
               end else if (!Anhalten) begin
                  r_lesen   <= 1'b1;
                  r_adresse <= r_pc;
               end
            end

            // One quiet cycle so Instruktion is settled before the capture edge.
            BEREITSTELLEN: begin
               r_dekodier <= 1'b1;
               r_zustand  <= AUSGABE;
            end

            AUSGABE: begin
               r_dekodier <= 1'b0;
               r_zustand  <= WARTEN;
            end

            WARTEN: begin
`ifdef VORABRUF_EN
               if (Weiter) begin
                  r_pc            <= w_naechsterPc;
                  r_pufferGueltig <= 1'b0;
                  if (!SprungAktiv && (r_pufferGueltig || (r_lesen && speicher.SpeicherBereit))) begin
                     // Sequential step served from the buffer (or the word arriving now).
                     r_instruktion <= r_pufferGueltig ? r_pufferDaten   : speicher.SpeicherDaten;
                     r_aktuellerPc <= r_pufferGueltig ? r_pufferAdresse : r_adresse;
                     r_lesen       <= 1'b0;
                     r_zustand     <= BEREITSTELLEN;
                  end else if (r_lesen) begin
                     // Prefetch in flight: sequential reuses it, a jump discards it.
                     r_zustand <= HOLEN;
                     if (speicher.SpeicherBereit) begin
                        r_lesen <= 1'b0;
                     end else begin
                        r_verwerfen <= SprungAktiv;
                     end
                  end else begin
                     r_zustand <= HOLEN;
                     r_lesen   <= !Anhalten;
                     r_adresse <= w_naechsterPc;
                  end
               end else if (r_lesen) begin
                  if (speicher.SpeicherBereit) begin
                     r_pufferDaten   <= speicher.SpeicherDaten;
                     r_pufferAdresse <= r_adresse;
                     r_pufferGueltig <= 1'b1;
                     r_lesen         <= 1'b0;
                  end
               end else if (!r_pufferGueltig && !Anhalten) begin
                  r_lesen   <= 1'b1;
                  r_adresse <= w_folgePc;
               end
`else
               // Weiter is accepted even while halted; only the request waits.
               if (Weiter) begin
                  r_pc      <= w_naechsterPc;
                  r_adresse <= w_naechsterPc;
                  r_lesen   <= !Anhalten;
                  r_zustand <= HOLEN;
               end
`endif
            end

            default: r_zustand <= HOLEN;
         endcase
      end
   end

endmodule
`default_nettype wire
